// File: rtl/cmp_result_tracker.sv
// ---------------------------------------------------------------------------
// cmp_result_tracker
//
// Downstream stage of the 4-bit magnitude comparator. Each accepted operand
// pair is registered for the next stage as (larger operand, compare code).
// The stage also keeps saturating gt/eq/lt tallies, pulses `streak` when
// RUN_LEN identical codes arrive back to back, and traps illegal codes.
//
// Parameters
//   CNT_W        width of each saturating result counter
//   RUN_LEN      consecutive identical codes that raise streak (2..15)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   clr          synchronous clear of counters, streak FSM and err
//   in_valid     input pair valid
//   in_ready     stage can accept input (combinational)
//   in_a, in_b   operands
//   in_cmp       comparator code: [2]=a>b, [1]=a==b, [0]=a<b
//   out_valid    output register holds a sample
//   out_ready    consumer accepts output
//   out_max      larger operand (in_a when equal)
//   out_code     in_cmp of the held sample
//   gt_cnt       accepted legal samples with code 3'b100
//   eq_cnt       accepted legal samples with code 3'b010
//   lt_cnt       accepted legal samples with code 3'b001
//   streak       one-cycle pulse: run reached RUN_LEN
//   streak_code  code of the current run (meaningful in RUN/LOCKED)
//   err          sticky: an illegal in_cmp was accepted
//
// Streak FSM
//   state  | meaning
//   IDLE   | no run in progress (after reset or clr)
//   RUN    | run of streak_code in progress, run_len < RUN_LEN
//   LOCKED | run reached RUN_LEN and already pulsed; same code stays silent
// ---------------------------------------------------------------------------
module cmp_result_tracker #(
    parameter int CNT_W   = 8,
    parameter int RUN_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [2:0]       in_cmp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_max,
    output logic [2:0]       out_code,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic             streak,
    output logic [2:0]       streak_code,
    output logic             err
);

    localparam logic [2:0]       CODE_GT   = 3'b100;
    localparam logic [2:0]       CODE_EQ   = 3'b010;
    localparam logic [2:0]       CODE_LT   = 3'b001;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       RUN_LEN_C = 4'(RUN_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] run_len;
    logic [3:0] run_len_inc;

    logic       accept;
    logic       legal;
    logic       acc_legal;
    logic       acc_illegal;
    logic       same_code;
    logic [3:0] max_val;

    // ------------------------------------------------------------------
    // Handshake and decode
    // ------------------------------------------------------------------
    // One-entry output register: accept whenever it is empty or being
    // drained this cycle.
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;

    assign legal       = (in_cmp == CODE_GT) || (in_cmp == CODE_EQ) ||
                         (in_cmp == CODE_LT);
    assign acc_legal   = accept && legal;
    assign acc_illegal = accept && !legal;

    // The comparator already decided; trust its code rather than compare
    // again, so a downstream mismatch points at the comparator.
    assign max_val     = in_cmp[0] ? in_b : in_a;

    assign same_code   = (in_cmp == streak_code);
    assign run_len_inc = run_len + 4'd1;

    // ------------------------------------------------------------------
    // Output register. clr deliberately does not touch it: a sample
    // accepted during clr still flows downstream.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_max   <= 4'd0;
            out_code  <= 3'd0;
        end else if (acc_legal) begin
            out_valid <= 1'b1;
            out_max   <= max_val;
            out_code  <= in_cmp;
        end else if (out_ready) begin
            // Covers plain drains and illegal accepts, which are dropped.
            out_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating result counters and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt_cnt <= '0;
            eq_cnt <= '0;
            lt_cnt <= '0;
            err    <= 1'b0;
        end else if (clr) begin
            gt_cnt <= '0;
            eq_cnt <= '0;
            lt_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (acc_legal && in_cmp == CODE_GT && gt_cnt != CNT_MAX)
                gt_cnt <= gt_cnt + CNT_ONE;
            if (acc_legal && in_cmp == CODE_EQ && eq_cnt != CNT_MAX)
                eq_cnt <= eq_cnt + CNT_ONE;
            if (acc_legal && in_cmp == CODE_LT && lt_cnt != CNT_MAX)
                lt_cnt <= lt_cnt + CNT_ONE;
            if (acc_illegal)
                err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Streak FSM with registered pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            run_len     <= 4'd0;
            streak      <= 1'b0;
            streak_code <= 3'd0;
        end else if (clr) begin
            state       <= IDLE;
            run_len     <= 4'd0;
            streak      <= 1'b0;
            streak_code <= 3'd0;
        end else begin
            streak <= 1'b0;
            if (acc_legal) begin
                case (state)
                    IDLE: begin
                        // RUN_LEN >= 2, so a single sample never pulses.
                        state       <= RUN;
                        run_len     <= 4'd1;
                        streak_code <= in_cmp;
                    end
                    RUN: begin
                        if (same_code) begin
                            run_len <= run_len_inc;
                            if (run_len_inc == RUN_LEN_C) begin
                                streak <= 1'b1;
                                state  <= LOCKED;
                            end
                        end else begin
                            run_len     <= 4'd1;
                            streak_code <= in_cmp;
                        end
                    end
                    LOCKED: begin
                        // Same code keeps the lock silently; run_len is
                        // frozen at RUN_LEN so it cannot wrap.
                        if (!same_code) begin
                            state       <= RUN;
                            run_len     <= 4'd1;
                            streak_code <= in_cmp;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        run_len <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmp_result_tracker.sv
module tb_cmp_result_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_cmp;
    logic       out_ready;

    logic       in_ready,  in_ready2;
    logic       out_valid, out_valid2;
    logic [3:0] out_max,   out_max2;
    logic [2:0] out_code,  out_code2;
    logic [7:0] gt_cnt, eq_cnt, lt_cnt;
    logic [1:0] gt_cnt2, eq_cnt2, lt_cnt2;
    logic       streak, streak2;
    logic [2:0] streak_code, streak_code2;
    logic       err, err2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cmp_result_tracker #(.CNT_W(8), .RUN_LEN(3)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cmp(in_cmp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_code(out_code),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt),
        .streak(streak), .streak_code(streak_code), .err(err)
    );

    cmp_result_tracker #(.CNT_W(2), .RUN_LEN(3)) dut_sat (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_cmp(in_cmp),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_max(out_max2), .out_code(out_code2),
        .gt_cnt(gt_cnt2), .eq_cnt(eq_cnt2), .lt_cnt(lt_cnt2),
        .streak(streak2), .streak_code(streak_code2), .err(err2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pair for one cycle; caller guarantees in_ready is high.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cmp   = c;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
        in_a = 4'd0; in_b = 4'd0; in_cmp = 3'd0; out_ready = 1'b0;
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_streak", streak, 0);
        rst = 1'b0;
        tick();

        // 1: reset in the middle of a held transfer
        send(4'd5, 4'd2, 3'b100);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_max", out_max, 5);
        chk("pre_rst_gt", gt_cnt, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_max", out_max, 0);
        chk("async_rst_code", out_code, 0);
        chk("async_rst_gt", gt_cnt, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_streak", streak, 0);
        chk("post_rst_err", err, 0);

        // 2: pass-through, including drain+accept in the same cycle
        out_ready = 1'b1;
        send(4'd1, 4'd3, 3'b001);
        chk("pt1_valid", out_valid, 1);
        chk("pt1_max", out_max, 3);
        chk("pt1_code", out_code, 3'b001);
        send(4'd13, 4'd11, 3'b100);
        chk("pt2_valid", out_valid, 1);
        chk("pt2_max", out_max, 13);
        send(4'd3, 4'd3, 3'b010);
        chk("pt3_max", out_max, 3);
        chk("pt3_code", out_code, 3'b010);
        chk("pt3_streak", streak, 0);
        tick();
        chk("pt_drain_valid", out_valid, 0);
        chk("pt_lt", lt_cnt, 1);
        chk("pt_gt", gt_cnt, 1);
        chk("pt_eq", eq_cnt, 1);

        // 3: backpressure
        out_ready = 1'b0;
        send(4'd7, 4'd2, 3'b100);
        chk("bp_first_max", out_max, 7);
        chk("bp_ready_low", in_ready, 0);
        in_valid = 1'b1; in_a = 4'd4; in_b = 4'd9; in_cmp = 3'b001;
        tick();
        chk("bp_hold_max", out_max, 7);
        chk("bp_hold_code", out_code, 3'b100);
        tick();
        chk("bp_hold2_max", out_max, 7);
        chk("bp_hold_lt", lt_cnt, 1);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_high", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_second_max", out_max, 9);
        chk("bp_second_code", out_code, 3'b001);
        chk("bp_second_valid", out_valid, 1);
        tick();
        chk("bp_drain_valid", out_valid, 0);
        chk("bp_gt", gt_cnt, 2);
        chk("bp_lt", lt_cnt, 2);

        // 4: streak on 100 x4 then 001
        send(4'd8, 4'd1, 3'b100);
        chk("stk1", streak, 0);
        send(4'd8, 4'd1, 3'b100);
        chk("stk2", streak, 0);
        send(4'd8, 4'd1, 3'b100);
        chk("stk3_pulse", streak, 1);
        chk("stk3_code", streak_code, 3'b100);
        send(4'd8, 4'd1, 3'b100);
        chk("stk4_no_pulse", streak, 0);
        send(4'd1, 4'd8, 3'b001);
        chk("stk5_no_pulse", streak, 0);
        chk("stk5_code", streak_code, 3'b001);
        chk("stk_gt", gt_cnt, 6);
        chk("stk_gt_sat", gt_cnt2, 3);
        tick();

        // 5: illegal codes are dropped and flagged
        send(4'd6, 4'd1, 3'b011);
        chk("ill1_err", err, 1);
        chk("ill1_valid", out_valid, 0);
        send(4'd6, 4'd1, 3'b000);
        chk("ill2_err", err, 1);
        chk("ill2_valid", out_valid, 0);
        chk("ill_gt", gt_cnt, 6);
        chk("ill_lt", lt_cnt, 3);
        chk("ill_eq", eq_cnt, 1);
        // FSM still in a 001 run of length 1: two more 001 complete it.
        send(4'd2, 4'd5, 3'b001);
        chk("ill_run2", streak, 0);
        send(4'd2, 4'd5, 3'b001);
        chk("ill_run3_pulse", streak, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_err", err, 0);
        chk("clr_gt", gt_cnt, 0);
        chk("clr_lt", lt_cnt, 0);
        chk("clr_eq", eq_cnt, 0);

        // 6: saturation and clr with a simultaneous accept
        for (int i = 1; i <= 5; i++) begin
            send(4'd9, 4'd1, 3'b100);
            chk("sat_gt2", gt_cnt2, (i > 3) ? 3 : i);
        end
        chk("sat_gt8", gt_cnt, 5);
        clr = 1'b1;
        send(4'd2, 4'd12, 3'b001);
        clr = 1'b0;
        chk("clracc_valid", out_valid, 1);
        chk("clracc_max", out_max, 12);
        chk("clracc_max_sat", out_max2, 12);
        chk("clracc_code", out_code, 3'b001);
        chk("clracc_gt2", gt_cnt2, 0);
        chk("clracc_lt2", lt_cnt2, 0);
        chk("clracc_lt", lt_cnt, 0);
        send(4'd2, 4'd12, 3'b001);
        chk("clracc_run1", streak, 0);
        send(4'd2, 4'd12, 3'b001);
        chk("clracc_run2", streak, 0);
        send(4'd2, 4'd12, 3'b001);
        chk("clracc_run3_pulse", streak, 1);
        chk("clracc_lt_after", lt_cnt, 3);
        chk("clracc_lt2_after", lt_cnt2, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
